mod_id_pipe: RTL
================

Name: mod_id_pipe

Overview:
Parametrised decode stage for the pipelined CPU. It contains:
- decode of the 16-bit ISA;
- a 2^REG_AW-entry register file;
- branch resolution in ID;
- load-use, branch and flag hazard stalling;
- a registered ID/EX output stage with valid/ready handshake.

Upstream is IF; downstream is EX.

Parameters:
DATA_W, 16, register/datapath width (>=16); immediates sign/zero-extended to DATA_W
REG_AW, 4, register index width; register 0 reads 0, writes ignored

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  IF presents instr
in_ready  out  1  ID accepts instr this cycle
instr  in  16  instruction
pc_in  in  DATA_W  PC+2 of instr
flags  in  3  {Z,V,N} architectural flags
wb_en  in  1  writeback enable
wb_reg  in  REG_AW  writeback index
wb_data  in  DATA_W  writeback data
mem_regwrite  in  1  EX/MEM instr writes a register
mem_dst  in  REG_AW  EX/MEM destination
ex_ready  in  1  EX accepts ID/EX contents
out_valid  out  1  ID/EX holds a valid instr
ex_ctrl  out  9  {regwrite,alusrc,memread,memwrite,memtoreg,aluop[3:0]}
ex_dst, ex_src1, ex_src2  out  REG_AW each  register indices
ex_data1, ex_data2, ex_imm  out  DATA_W each  operands, immediate
redirect  out  1  taken branch accepted this cycle
redirect_pc  out  DATA_W  branch target
halt  out  1  sticky HLT seen

Behaviour:
- Reset (rst=0, async): register file, all ID/EX fields, out_valid and halt go to 0.
- Opcodes:
  - 0x0-0x7: ALU ops; aluop=opcode; flag writers are 0x0-0x2 and 0x4-0x6.
  - 0x8: LW. 0x9: SW. 0xA: LLB. 0xB: LHB. 0xC: B. 0xD: BR. 0xE: PCS. 0xF: HLT.
- Sources: src1=instr[7:4], except LLB/LHB, where src1=instr[11:8]. src2=instr[3:0], except SW, where src2=instr[11:8].
- Immediates:
  - LW/SW/shifts: sext(instr[3:0]).
  - LLB/LHB: zext(instr[7:0]).
- PCS: ex_data1=pc_in.
- Branch B:
  - cond=instr[11:9]; 000 NE, 001 EQ, 010 GT, 011 LT, 100 GE, 101 LE, 110 OV, 111 always.
  - target = pc_in + sext({instr[8:0],0}).
- Branch BR: target = reg[instr[7:4]], same condition codes.
- Handshake:
  - stall = load_use | br_hazard | flag_hazard (| wb_hazard, see the optional feature).
  - in_ready = ~halt & ~stall & (ex_ready | ~out_valid).
  - accept = in_valid & in_ready.
- ID/EX update when ex_ready | ~out_valid:
  - on accept, load the decoded instr and set out_valid=1;
  - otherwise load a bubble (out_valid=0).
- ID/EX hold when ~ex_ready & out_valid: hold contents.
- Hazards:
  - load_use: ID/EX valid LW with dst!=0 matching a used source of instr.
  - br_hazard: BR whose rs matches a nonzero dst of a valid regwrite in ID/EX, or mem_dst with mem_regwrite.
  - flag_hazard: B/BR with cond!=111 while ID/EX holds a valid flag writer.
- Latency: one cycle from accept to out_valid.
- Stall insertion: each stall cycle with ex_ready=1 inserts exactly one bubble.
- redirect:
  - combinational; asserts only in the accept cycle of a taken B/BR;
  - IF discards its fetch that cycle;
  - the branch itself enters ID/EX with no writes.
- HLT:
  - accepted HLT passes as a no-write instr;
  - halt=1 from the next cycle until reset; in_ready=0 thereafter.
- Reset asserted mid-operation clears state immediately; no redirect is issued while reset is asserted.

Optional Feature:
Macro ID_WB_BYPASS_EN.
- Defined: a same-cycle writeback to a nonzero register being read returns wb_data on the read port; wb_hazard=0.
- Undefined: reads return the old value; wb_hazard stalls one cycle when wb_en & wb_reg!=0 matches a used source.

Decomposition:
- Package id_pkg: opcode constants, condition-code constants, flag bit positions, ctrl field offsets, flag-writer predicate.
- One sub-module, id_regfile: 2 read ports, 1 write port, register 0 hard zero, bypass under the macro.

Test Plan:
- Reset, then ADD r1,r2,r3 with r2=5, r3=7 (written via WB) -> next cycle out_valid=1, ex_data1=5, ex_data2=7, aluop=0, regwrite=1.
- LW r4 then ADD r5,r4,r1 back-to-back, ex_ready=1 -> in_ready=0 for one cycle, one bubble, then ADD issues.
- SUB setting Z, then B EQ offset 4 with flags Z=1, pc_in=0x0010 -> one stall cycle, then redirect=1, redirect_pc=0x0018.
- ex_ready=0 for 3 cycles with out_valid=1 -> ID/EX holds constant, in_ready=0, no instr lost.
- HLT accepted -> halt=1 next cycle, in_ready stays 0; rst low -> halt=0, out_valid=0 immediately.
- wb_en to r2 with wb_data=0x1234 while reading r2 -> with macro ex_data1=0x1234, no stall; without macro one stall, then 0x1234.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: opcodes, branch conditions, flag and ctrl layout,
// plus the flag-writer and branch-condition helpers.
package id_pkg;

    typedef enum logic [3:0] {
        OpAdd    = 4'h0,
        OpSub    = 4'h1,
        OpXor    = 4'h2,
        OpRed    = 4'h3,
        OpSll    = 4'h4,
        OpSra    = 4'h5,
        OpRor    = 4'h6,
        OpPaddsb = 4'h7,
        OpLw     = 4'h8,
        OpSw     = 4'h9,
        OpLlb    = 4'hA,
        OpLhb    = 4'hB,
        OpB      = 4'hC,
        OpBr     = 4'hD,
        OpPcs    = 4'hE,
        OpHlt    = 4'hF
    } opcode_e;

    localparam logic [2:0] CondNe     = 3'b000;
    localparam logic [2:0] CondEq     = 3'b001;
    localparam logic [2:0] CondGt     = 3'b010;
    localparam logic [2:0] CondLt     = 3'b011;
    localparam logic [2:0] CondGe     = 3'b100;
    localparam logic [2:0] CondLe     = 3'b101;
    localparam logic [2:0] CondOv     = 3'b110;
    localparam logic [2:0] CondAlways = 3'b111;

    // Architectural flags arrive packed as {Z,V,N}.
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagV = 1;
    localparam int unsigned FlagN = 0;

    localparam int unsigned CtrlW        = 9;
    localparam int unsigned CtrlRegwrite = 8;
    localparam int unsigned CtrlAlusrc   = 7;
    localparam int unsigned CtrlMemread  = 6;
    localparam int unsigned CtrlMemwrite = 5;
    localparam int unsigned CtrlMemtoreg = 4;
    localparam int unsigned CtrlAluop    = 0;

    function automatic logic is_flag_writer(logic [3:0] op);
        return (op <= OpRor) && (op != OpRed);
    endfunction

    function automatic logic cond_taken(logic [2:0] cond, logic [2:0] flags);
        logic z;
        logic v;
        logic n;
        z = flags[FlagZ];
        v = flags[FlagV];
        n = flags[FlagN];
        case (cond)
            CondNe:  return !z;
            CondEq:  return z;
            CondGt:  return !z && !n;
            CondLt:  return n;
            CondGe:  return z || !n;
            CondLe:  return z || n;
            CondOv:  return v;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mod_id_pipe_if.sv
// ID/EX output bus: registered decode results toward EX with a valid/ready handshake.
interface mod_id_pipe_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
) ();
    import id_pkg::*;

    logic              out_valid;
    logic              ex_ready;
    logic [CtrlW-1:0]  ex_ctrl;
    logic [REG_AW-1:0] ex_dst;
    logic [REG_AW-1:0] ex_src1;
    logic [REG_AW-1:0] ex_src2;
    logic [DATA_W-1:0] ex_data1;
    logic [DATA_W-1:0] ex_data2;
    logic [DATA_W-1:0] ex_imm;

    modport master (
        output out_valid, ex_ctrl, ex_dst, ex_src1, ex_src2, ex_data1, ex_data2, ex_imm,
        input  ex_ready
    );

    modport slave (
        input  out_valid, ex_ctrl, ex_dst, ex_src1, ex_src2, ex_data1, ex_data2, ex_imm,
        output ex_ready
    );
endinterface

// File: rtl/id_regfile.sv
// Register file with two read ports and one write port; register 0 always reads zero.
// Define ID_WB_BYPASS_EN to return same-cycle write data on a matching read.
module id_regfile #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              wen,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);
    localparam int unsigned NumRegs = 1 << REG_AW;

    logic [DATA_W-1:0] regs_q [NumRegs];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '{default: '0};
        end else if (wen && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs_q[raddr1];
        rdata2 = regs_q[raddr2];
`ifdef ID_WB_BYPASS_EN
        if (wen && (waddr != '0) && (waddr == raddr1)) rdata1 = wdata;
        if (wen && (waddr != '0) && (waddr == raddr2)) rdata2 = wdata;
`endif
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/mod_id_pipe.sv
// ID stage: decode, register read, branch resolution in ID, hazard stalls and the ID/EX register.
// Define ID_WB_BYPASS_EN to forward writeback data instead of stalling on a same-cycle write.
module mod_id_pipe
    import id_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [2:0]        flags,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_dst,
    mod_id_pipe_if.master     ex_bus,
    output logic              redirect,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              halt
);
    opcode_e           op;
    logic [CtrlW-1:0]  ctrl;
    logic [REG_AW-1:0] dst, src1, src2;
    logic              use1, use2, is_b, is_br;
    logic [DATA_W-1:0] imm, rdata1, rdata2, data1, b_target;
    logic              taken, load_use, br_hazard, flag_hazard, wb_hazard, stall, accept;

    logic              out_valid_q, halt_q;
    logic [CtrlW-1:0]  ctrl_q;
    logic [REG_AW-1:0] dst_q, src1_q, src2_q;
    logic [DATA_W-1:0] data1_q, data2_q, imm_q;

    assign op = opcode_e'(instr[15:12]);

    always_comb begin
        ctrl                 = '0;
        ctrl[CtrlAluop +: 4] = instr[15:12];
        dst                  = '0;
        src1                 = REG_AW'(instr[7:4]);
        src2                 = REG_AW'(instr[3:0]);
        use1                 = 1'b0;
        use2                 = 1'b0;
        imm                  = '0;
        is_b                 = 1'b0;
        is_br                = 1'b0;
        unique case (op)
            OpAdd, OpSub, OpXor, OpRed, OpPaddsb: begin
                ctrl[CtrlRegwrite] = 1'b1;
                dst                = REG_AW'(instr[11:8]);
                use1               = 1'b1;
                use2               = 1'b1;
            end
            // Shifts carry their amount in the src2 field, so only src1 is read.
            OpSll, OpSra, OpRor: begin
                ctrl[CtrlRegwrite] = 1'b1;
                ctrl[CtrlAlusrc]   = 1'b1;
                dst                = REG_AW'(instr[11:8]);
                use1               = 1'b1;
                imm                = {{(DATA_W-4){instr[3]}}, instr[3:0]};
            end
            OpLw: begin
                ctrl[CtrlRegwrite] = 1'b1;
                ctrl[CtrlAlusrc]   = 1'b1;
                ctrl[CtrlMemread]  = 1'b1;
                ctrl[CtrlMemtoreg] = 1'b1;
                dst                = REG_AW'(instr[11:8]);
                use1               = 1'b1;
                imm                = {{(DATA_W-4){instr[3]}}, instr[3:0]};
            end
            OpSw: begin
                ctrl[CtrlAlusrc]   = 1'b1;
                ctrl[CtrlMemwrite] = 1'b1;
                src2               = REG_AW'(instr[11:8]);
                use1               = 1'b1;
                use2               = 1'b1;
                imm                = {{(DATA_W-4){instr[3]}}, instr[3:0]};
            end
            // LLB/LHB merge a byte into the old destination value, read through src1.
            OpLlb, OpLhb: begin
                ctrl[CtrlRegwrite] = 1'b1;
                ctrl[CtrlAlusrc]   = 1'b1;
                dst                = REG_AW'(instr[11:8]);
                src1               = REG_AW'(instr[11:8]);
                use1               = 1'b1;
                imm                = {{(DATA_W-8){1'b0}}, instr[7:0]};
            end
            OpB: is_b = 1'b1;
            OpBr: begin
                is_br = 1'b1;
                use1  = 1'b1;
            end
            OpPcs: begin
                ctrl[CtrlRegwrite] = 1'b1;
                dst                = REG_AW'(instr[11:8]);
            end
            default: ;
        endcase
    end

    id_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (src1),
        .raddr2 (src2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .wen    (wb_en),
        .waddr  (wb_reg),
        .wdata  (wb_data)
    );

    assign data1    = (op == OpPcs) ? pc_in : rdata1;
    assign taken    = (is_b | is_br) & cond_taken(instr[11:9], flags);
    assign b_target = pc_in + {{(DATA_W-10){instr[8]}}, instr[8:0], 1'b0};

    assign load_use = out_valid_q & ctrl_q[CtrlMemread] & (dst_q != '0) &
                      ((use1 & (dst_q == src1)) | (use2 & (dst_q == src2)));
    assign br_hazard = is_br &
        ((out_valid_q & ctrl_q[CtrlRegwrite] & (dst_q != '0) & (dst_q == src1)) |
         (mem_regwrite & (mem_dst != '0) & (mem_dst == src1)));
    assign flag_hazard = (is_b | is_br) & (instr[11:9] != CondAlways) & out_valid_q &
                         is_flag_writer(ctrl_q[CtrlAluop +: 4]);
`ifdef ID_WB_BYPASS_EN
    assign wb_hazard = 1'b0;
`else
    assign wb_hazard = wb_en & (wb_reg != '0) &
                       ((use1 & (wb_reg == src1)) | (use2 & (wb_reg == src2)));
`endif

    assign stall = load_use | br_hazard | flag_hazard | wb_hazard;
    // Gating with rst keeps IF from seeing an accept or redirect while held in reset.
    assign in_ready    = rst & ~halt_q & ~stall & (ex_bus.ex_ready | ~out_valid_q);
    assign accept      = in_valid & in_ready;
    assign redirect    = accept & taken;
    assign redirect_pc = is_br ? rdata1 : b_target;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            halt_q      <= 1'b0;
            ctrl_q      <= '0;
            dst_q       <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            imm_q       <= '0;
        end else begin
            if (accept && (op == OpHlt)) halt_q <= 1'b1;
            if (ex_bus.ex_ready || !out_valid_q) begin
                out_valid_q <= accept;
                ctrl_q      <= accept ? ctrl : '0;
                dst_q       <= dst;
                src1_q      <= src1;
                src2_q      <= src2;
                data1_q     <= data1;
                data2_q     <= rdata2;
                imm_q       <= imm;
            end
        end
    end

    assign ex_bus.out_valid = out_valid_q;
    assign ex_bus.ex_ctrl   = ctrl_q;
    assign ex_bus.ex_dst    = dst_q;
    assign ex_bus.ex_src1   = src1_q;
    assign ex_bus.ex_src2   = src2_q;
    assign ex_bus.ex_data1  = data1_q;
    assign ex_bus.ex_data2  = data2_q;
    assign ex_bus.ex_imm    = imm_q;
    assign halt             = halt_q;

endmodule
